// File: rtl/alu_activity_monitor_if.sv
// Handshake and sample bus between the ALU, the activity monitor and the report consumer.
interface alu_activity_monitor_if #(
  parameter int TOT_W = 16
);
  logic             start;
  logic             sample_valid;
  logic [3:0]       alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_overflow;
  logic             out_ready;
  logic             busy;
  logic             out_valid;
  logic [TOT_W-1:0] total_hd;
  logic [2:0]       max_hd;
  logic             alarm;

  modport master (
    output start, sample_valid, alu_result, alu_carry, alu_zero, alu_overflow, out_ready,
    input  busy, out_valid, total_hd, max_hd, alarm
  );

  modport slave (
    input  start, sample_valid, alu_result, alu_carry, alu_zero, alu_overflow, out_ready,
    output busy, out_valid, total_hd, max_hd, alarm
  );
endinterface

// File: rtl/alu_activity_monitor.sv
// Windowed Hamming-distance accumulator over consecutive ALU output samples,
// reporting saturated total, peak per-transition HD and a threshold alarm.
module alu_activity_monitor #(
  parameter int          WINDOW = 64,
  parameter int          CNT_W  = 8,
  parameter int          TOT_W  = 16,
  parameter int unsigned THRESH = 224
) (
  input logic                   clk,
  input logic                   rst,
  alu_activity_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRIME, ACCUM, REPORT} state_t;

  state_t           r_state;
  logic [6:0]       r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [TOT_W-1:0] r_acc;
  logic [2:0]       r_max;
  logic             r_busy;
  logic             r_out_valid;
  logic [TOT_W-1:0] r_total;
  logic [2:0]       r_max_o;
  logic             r_alarm;

  logic [6:0]       w_s;
  logic [6:0]       w_diff;
  logic [2:0]       w_hd;
  logic [TOT_W:0]   w_sum;
  logic [TOT_W-1:0] w_acc_nxt;
  logic [2:0]       w_max_nxt;
  logic             w_last;

  assign w_s    = {bus.alu_overflow, bus.alu_zero, bus.alu_carry, bus.alu_result};
  assign w_diff = r_prev ^ w_s;

  always_comb begin
    w_hd = '0;
    for (int i = 0; i < 7; i++) w_hd = w_hd + {2'b00, w_diff[i]};
  end

  // Carry out of the extended sum means the accumulator would wrap: pin it at all-ones.
  assign w_sum     = {1'b0, r_acc} + (TOT_W+1)'(w_hd);
  assign w_acc_nxt = w_sum[TOT_W] ? '1 : w_sum[TOT_W-1:0];
  assign w_max_nxt = (w_hd > r_max) ? w_hd : r_max;
  assign w_last    = (r_cnt == CNT_W'(WINDOW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prev      <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_max       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_total     <= '0;
      r_max_o     <= '0;
      r_alarm     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= PRIME;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_max   <= '0;
          r_total <= '0;
          r_max_o <= '0;
          r_alarm <= 1'b0;
        end
        PRIME: if (bus.sample_valid) begin
          r_prev  <= w_s;
          r_state <= ACCUM;
        end
        ACCUM: if (bus.sample_valid) begin
          r_prev <= w_s;
          r_acc  <= w_acc_nxt;
          r_max  <= w_max_nxt;
          r_cnt  <= r_cnt + 1'b1;
          // Report registers load together with the final transition.
          if (w_last) begin
            r_state     <= REPORT;
            r_out_valid <= 1'b1;
            r_total     <= w_acc_nxt;
            r_max_o     <= w_max_nxt;
            r_alarm     <= (32'(w_acc_nxt) > THRESH);
          end
        end
        REPORT: if (bus.out_ready) begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.total_hd  = r_total;
  assign bus.max_hd    = r_max_o;
  assign bus.alarm     = r_alarm;
endmodule

// File: tb/tb_alu_activity_monitor.sv
// Directed bench: two monitors (16-bit and 4-bit totals, WINDOW=4) driven with identical stimulus.
module tb_alu_activity_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_activity_monitor_if #(.TOT_W(16)) ifa ();
  alu_activity_monitor_if #(.TOT_W(4))  ifs ();

  alu_activity_monitor #(.WINDOW(4), .CNT_W(8), .TOT_W(16), .THRESH(20))
    u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  alu_activity_monitor #(.WINDOW(4), .CNT_W(8), .TOT_W(4), .THRESH(224))
    u_s (.clk(clk), .rst(rst), .bus(ifs.slave));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sv, input logic [6:0] s, input logic rdy);
    ifa.start = st; ifs.start = st;
    ifa.sample_valid = sv; ifs.sample_valid = sv;
    {ifa.alu_overflow, ifa.alu_zero, ifa.alu_carry, ifa.alu_result} = s;
    {ifs.alu_overflow, ifs.alu_zero, ifs.alu_carry, ifs.alu_result} = s;
    ifa.out_ready = rdy; ifs.out_ready = rdy;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 7'h7F, 1'b0);
    repeat (n) step();
  endtask

  task automatic send(input logic [6:0] s);
    drive(1'b0, 1'b1, s, 1'b0);
    step();
    drive(1'b0, 1'b0, 7'h55, 1'b0);
  endtask

  task automatic go();
    drive(1'b1, 1'b0, 7'h00, 1'b0);
    step();
    drive(1'b0, 1'b0, 7'h00, 1'b0);
  endtask

  task automatic accept();
    drive(1'b0, 1'b0, 7'h00, 1'b1);
    step();
    drive(1'b0, 1'b0, 7'h00, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 7'h00, 1'b0);
    #12 rst = 1'b0;
    idle(10);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_ov", ifa.out_valid, 0);
    chk("rst_total", ifa.total_hd, 0);

    // Alternating activity: 4 transitions of HD 7
    go();
    chk("alt_busy", ifa.busy, 1);
    send(7'h00); send(7'h7F); send(7'h00); send(7'h7F);
    chk("alt_ov_early", ifa.out_valid, 0);
    send(7'h00);
    chk("alt_ov", ifa.out_valid, 1);
    chk("alt_total", ifa.total_hd, 28);
    chk("alt_max", ifa.max_hd, 7);
    chk("alt_alarm", ifa.alarm, 1);
    chk("alt_sat_total", ifs.total_hd, 15);
    chk("alt_sat_alarm", ifs.alarm, 0);
    accept();
    chk("alt_ov_done", ifa.out_valid, 0);
    chk("alt_busy_done", ifa.busy, 0);
    chk("alt_total_kept", ifa.total_hd, 28);

    // Asynchronous reset while holding a report
    go();
    send(7'h00); send(7'h7F); send(7'h00); send(7'h7F); send(7'h00);
    chk("ar_pre_ov", ifa.out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("ar_ov", ifa.out_valid, 0);
    chk("ar_busy", ifa.busy, 0);
    chk("ar_total", ifa.total_hd, 0);
    chk("ar_max", ifa.max_hd, 0);
    chk("ar_alarm", ifa.alarm, 0);
    @(negedge clk) rst = 1'b0;
    idle(10);
    chk("ar_idle_busy", ifa.busy, 0);
    chk("ar_idle_ov", ifa.out_valid, 0);

    // Quiet window
    go();
    repeat (5) send(7'h15);
    chk("q_ov", ifa.out_valid, 1);
    chk("q_total", ifa.total_hd, 0);
    chk("q_max", ifa.max_hd, 0);
    chk("q_alarm", ifa.alarm, 0);
    accept();

    // Gaps between samples, then backpressure; start during handshake must be ignored
    go();
    send(7'h00); idle(2);
    send(7'h01); idle(2);
    send(7'h03); idle(2);
    send(7'h07); idle(2);
    chk("gap_ov_early", ifa.out_valid, 0);
    send(7'h0F);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", ifa.out_valid, 1);
      chk("bp_total", ifa.total_hd, 4);
      chk("bp_max", ifa.max_hd, 1);
      drive(1'b0, 1'b1, 7'h7F, 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 7'h00, 1'b1);
    step();
    drive(1'b0, 1'b0, 7'h00, 1'b0);
    chk("bp_ov_done", ifa.out_valid, 0);
    chk("bp_busy_done", ifa.busy, 0);
    idle(2);
    chk("bp_start_ignored", ifa.busy, 0);

    // Saturation with a stray start during ACCUM
    go();
    send(7'h00);
    go();
    send(7'h7F); send(7'h00); send(7'h7F); send(7'h00);
    chk("sat_ov", ifs.out_valid, 1);
    chk("sat_total", ifs.total_hd, 15);
    chk("sat_max", ifs.max_hd, 7);
    chk("sat_alarm", ifs.alarm, 0);
    chk("sat_wide_total", ifa.total_hd, 28);
    accept();

    // Reset mid-window, then a clean window of identical samples
    go();
    send(7'h00); send(7'h7F); send(7'h00);
    chk("mw_busy", ifa.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mw_rst_busy", ifa.busy, 0);
    chk("mw_rst_total", ifa.total_hd, 0);
    @(negedge clk) rst = 1'b0;
    idle(2);
    go();
    repeat (5) send(7'h00);
    chk("mw_ov", ifa.out_valid, 1);
    chk("mw_total", ifa.total_hd, 0);
    chk("mw_max", ifa.max_hd, 0);
    chk("mw_alarm", ifa.alarm, 0);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
